// File: rtl/lpf_iir1_mc.sv
// ---------------------------------------------------------------------------
// lpf_iir1_mc
//   Multi-channel, time-multiplexed first-order bilinear low-pass filter.
//   Per channel:  y(k) = y(k-1) - y(k-1)/2^K + (x(k)+x(k-1))/2^(K+1)
//   The state kept per channel is acc = y * 2^(K+1) plus the previous input,
//   so the whole update is adds, subtracts and arithmetic shifts.
//
//   Pipeline: stage 0 registers the incoming sample, stage 1 updates the
//   channel state and registers the (saturated) result. Result appears
//   exactly 2 clocks after the sample, one sample per clock sustained.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of all channel state and in-flight samples
//   bypass    1: result equals the input sample (state still updated)
//   k_sel     requested shift, clamped to [K_MIN, K_MAX], taken per sample
//   in_valid  sample strobe
//   in_ch     channel of the sample (>= CH is dropped)
//   in_data   signed input sample
//   out_valid result strobe
//   out_ch    channel of the result
//   out_data  signed filtered sample
//   out_sat   out_data was clamped for this result
// ---------------------------------------------------------------------------
module lpf_iir1_mc #(
  parameter int W     = 17,
  parameter int CH    = 4,
  parameter int K_MIN = 1,
  parameter int K_MAX = 6,
  parameter int K_RST = 3,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
  localparam int KW   = $clog2(K_MAX + 1),
  localparam int AW   = W + K_MAX + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                bypass,
  input  logic [KW-1:0]       k_sel,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_ch,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_data,
  output logic                out_sat
);

  localparam logic signed [AW-1:0] Y_MAX = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

  // Stage 0 registers
  logic                s0_valid_q;
  logic [CW-1:0]       s0_ch_q;
  logic signed [W-1:0] s0_data_q;
  logic                s0_byp_q;
  logic [KW-1:0]       k_q;

  // Per-channel filter state
  logic signed [AW-1:0] acc_q   [CH];
  logic signed [W-1:0]  xprev_q [CH];

  // Output registers
  logic                out_valid_q;
  logic [CW-1:0]       out_ch_q;
  logic signed [W-1:0] out_data_q;
  logic                out_sat_q;

  // Stage 0 / stage 1 combinational signals
  logic [KW-1:0]        k_d;
  logic                 ch_ok_s;
  logic signed [AW-1:0] acc_cur_s;
  logic signed [AW-1:0] x_ext_s;
  logic signed [AW-1:0] xp_ext_s;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] y_full_s;
  logic [KW:0]          ksh_s;
  logic signed [W-1:0]  out_data_d;
  logic                 out_sat_d;

  // Clamp the requested shift and qualify the channel number
  always_comb begin
    k_d = k_sel;
    if (k_sel < KW'(K_MIN)) begin
      k_d = KW'(K_MIN);
    end else if (k_sel > KW'(K_MAX)) begin
      k_d = KW'(K_MAX);
    end else begin
      k_d = k_sel;
    end
    // One extra bit keeps the compare from being constant when CH == 2^CW
    ch_ok_s = ({1'b0, in_ch} < (CW + 1)'(CH));
  end

  // Stage 1 datapath: state update and output saturation
  always_comb begin
    acc_cur_s  = acc_q[s0_ch_q];
    x_ext_s    = {{(AW - W){s0_data_q[W-1]}}, s0_data_q};
    xp_ext_s   = {{(AW - W){xprev_q[s0_ch_q][W-1]}}, xprev_q[s0_ch_q]};
    acc_d      = x_ext_s + xp_ext_s + acc_cur_s - (acc_cur_s >>> k_q);
    ksh_s      = {1'b0, k_q} + (KW + 1)'(1);
    y_full_s   = acc_d >>> ksh_s;
    out_data_d = y_full_s[W-1:0];
    out_sat_d  = 1'b0;
    if (s0_byp_q) begin
      out_data_d = s0_data_q;
      out_sat_d  = 1'b0;
    end else if (y_full_s > Y_MAX) begin
      out_data_d = Y_MAX[W-1:0];
      out_sat_d  = 1'b1;
    end else if (y_full_s < Y_MIN) begin
      out_data_d = Y_MIN[W-1:0];
      out_sat_d  = 1'b1;
    end else begin
      out_data_d = y_full_s[W-1:0];
      out_sat_d  = 1'b0;
    end
  end

  // Stage 0: capture accepted sample and its shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_ch_q    <= '0;
      s0_data_q  <= '0;
      s0_byp_q   <= 1'b0;
      k_q        <= KW'(K_RST);
    end else if (clr) begin
      s0_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= in_valid & ch_ok_s;
      if (in_valid) begin
        s0_ch_q   <= in_ch;
        s0_data_q <= in_data;
        s0_byp_q  <= bypass;
        k_q       <= k_d;
      end
    end
  end

  // Channel state: written by stage 1, read back combinationally next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        acc_q[c]   <= '0;
        xprev_q[c] <= '0;
      end
    end else if (clr) begin
      for (int c = 0; c < CH; c++) begin
        acc_q[c]   <= '0;
        xprev_q[c] <= '0;
      end
    end else if (s0_valid_q) begin
      acc_q[s0_ch_q]   <= acc_d;
      xprev_q[s0_ch_q] <= s0_data_q;
    end
  end

  // Stage 1 output registers; data fields hold while no result is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        out_ch_q   <= s0_ch_q;
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_lpf_iir1_mc.sv
// ---------------------------------------------------------------------------
// tb_lpf_iir1_mc
//   Directed-vector bench for lpf_iir1_mc. Every clock the output is compared
//   with a small integer model of the filter equation (floor division), and
//   the key values are additionally checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lpf_iir1_mc;

  localparam int W  = 17;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int KW = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clr;
  logic                bypass;
  logic [KW-1:0]       k_sel;
  logic                in_valid;
  logic [CW-1:0]       in_ch;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic [CW-1:0]       out_ch;
  logic signed [W-1:0] out_data;
  logic                out_sat;

  lpf_iir1_mc #(.W(W), .CH(CH), .K_MIN(1), .K_MAX(6), .K_RST(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bypass    (bypass),
    .k_sel     (k_sel),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit     v;
    int     ch;
    longint d;
    bit     s;
  } exp_t;

  longint m_acc [CH];
  longint m_xp  [CH];
  longint last_y[CH];
  exp_t   pend;
  longint last_ch, last_d, last_s;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    else return -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_xp[c]  = 0;
    end
  endtask

  // One clock: apply inputs, advance the model, check the output due now.
  task automatic drive(input bit v, input int ch, input int x, input int ks,
                       input bit byp, input bit c);
    exp_t   nx;
    longint an, y;
    int     k;
    nx.v = 1'b0; nx.ch = 0; nx.d = 0; nx.s = 1'b0;
    in_valid = v;
    in_ch    = ch[CW-1:0];
    in_data  = x[W-1:0];
    k_sel    = ks[KW-1:0];
    bypass   = byp;
    clr      = c;
    if (c) begin
      model_reset();
      pend.v = 1'b0;
    end else if (v && ch < CH) begin
      k  = (ks < 1) ? 1 : ((ks > 6) ? 6 : ks);
      an = x + m_xp[ch] + m_acc[ch] - fdiv(m_acc[ch], longint'(1) << k);
      y  = fdiv(an, longint'(1) << (k + 1));
      m_acc[ch] = an;
      m_xp[ch]  = x;
      nx.v  = 1'b1;
      nx.ch = ch;
      if (byp) begin
        nx.d = x; nx.s = 1'b0;
      end else if (y > 65535) begin
        nx.d = 65535; nx.s = 1'b1;
      end else if (y < -65536) begin
        nx.d = -65536; nx.s = 1'b1;
      end else begin
        nx.d = y; nx.s = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (pend.v) begin
      check_val("out_valid", out_valid, 1);
      check_val("out_ch", out_ch, pend.ch);
      check_val("out_data", $signed(out_data), pend.d);
      check_val("out_sat", out_sat, pend.s);
      last_ch = pend.ch;
      last_d  = pend.d;
      last_s  = pend.s;
      last_y[pend.ch] = $signed(out_data);
    end else begin
      check_val("out_valid_idle", out_valid, 0);
      check_val("out_ch_hold", out_ch, last_ch);
      check_val("out_data_hold", $signed(out_data), last_d);
      check_val("out_sat_hold", out_sat, last_s);
    end
    pend = nx;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 3, 1'b0, 1'b0);
  endtask

  function automatic bit near(input longint a, input longint b);
    return (a - b <= 1) && (b - a <= 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; bypass = 1'b0; k_sel = 3'd3;
    in_valid = 1'b0; in_ch = 2'd0; in_data = 17'sd0;
    model_reset();
    for (int c = 0; c < CH; c++) last_y[c] = 0;
    pend.v = 1'b0; pend.ch = 0; pend.d = 0; pend.s = 1'b0;
    last_ch = 0; last_d = 0; last_s = 0;

    // 1: reset state, mid-stream reset, first sample after reset
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_ch", out_ch, 0);
    check_val("rst_data", $signed(out_data), 0);
    check_val("rst_sat", out_sat, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1, 1000 + 100 * i, 3, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_ch", out_ch, 0);
    check_val("midrst_data", $signed(out_data), 0);
    check_val("midrst_sat", out_sat, 0);
    in_valid = 1'b0;
    model_reset();
    pend.v = 1'b0; last_ch = 0; last_d = 0; last_s = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 0, 1000, 3, 1'b0, 1'b0);
    idle();
    check_val("t1_first", $signed(out_data), 62);

    // 2: DC step on ch0 from cleared state
    drive(1'b0, 0, 0, 3, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, 0, 1000, 3, 1'b0, 1'b0);
      if (i == 1) check_val("t2_y0", $signed(out_data), 62);
      if (i == 2) check_val("t2_y1", $signed(out_data), 179);
    end
    check_val("t2_dc", near($signed(out_data), 1000), 1);
    idle();
    idle();

    // 3: interleaved channels with a same-channel burst
    drive(1'b0, 0, 0, 3, 1'b0, 1'b1);
    for (int p = 0; p < 70; p++) begin
      drive(1'b1, 0, 8000, 3, 1'b0, 1'b0);
      drive(1'b1, 1, -8000, 3, 1'b0, 1'b0);
      drive(1'b1, 0, 8000, 3, 1'b0, 1'b0);
      drive(1'b1, 1, -8000, 3, 1'b0, 1'b0);
      for (int b = 0; b < 3; b++) drive(1'b1, 3, 3000, 3, 1'b0, 1'b0);
    end
    idle();
    idle();
    check_val("t3_ch0", near(last_y[0], 8000), 1);
    check_val("t3_ch1", near(last_y[1], -8000), 1);
    check_val("t3_ch3", near(last_y[3], 3000), 1);
    drive(1'b1, 2, 0, 3, 1'b0, 1'b0);
    idle();
    check_val("t3_ch2_data", $signed(out_data), 0);
    check_val("t3_ch2_ch", out_ch, 2);

    // 4: saturation after shift change, both polarities; k_sel clamping
    drive(1'b0, 0, 0, 3, 1'b0, 1'b1);
    for (int i = 0; i < 1200; i++) drive(1'b1, 0, 30000, 6, 1'b0, 1'b0);
    idle();
    check_val("t4_ss", near($signed(out_data), 30000), 1);
    drive(1'b1, 0, 30000, 1, 1'b0, 1'b0);
    idle();
    check_val("t4_pos_data", $signed(out_data), 65535);
    check_val("t4_pos_sat", out_sat, 1);
    drive(1'b0, 0, 0, 3, 1'b0, 1'b1);
    for (int i = 0; i < 1200; i++) drive(1'b1, 0, -30000, 7, 1'b0, 1'b0);
    drive(1'b1, 0, -30000, 0, 1'b0, 1'b0);
    idle();
    check_val("t4_neg_data", $signed(out_data), -65536);
    check_val("t4_neg_sat", out_sat, 1);

    // 5: sample presented with clr is discarded
    drive(1'b1, 0, 500, 3, 1'b0, 1'b1);
    check_val("t5_gap0", out_valid, 0);
    drive(1'b1, 0, 500, 3, 1'b0, 1'b0);
    check_val("t5_gap1", out_valid, 0);
    idle();
    check_val("t5_out", $signed(out_data), 31);
    check_val("t5_sat", out_sat, 0);

    // 6: bypass on ch2, then filtering continues from its state
    drive(1'b1, 2, -1234, 3, 1'b1, 1'b0);
    idle();
    check_val("t6_byp_data", $signed(out_data), -1234);
    check_val("t6_byp_ch", out_ch, 2);
    check_val("t6_byp_sat", out_sat, 0);
    drive(1'b1, 2, -1234, 3, 1'b0, 1'b0);
    idle();
    check_val("t6_cont", $signed(out_data), -222);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
